// File: rtl/uart_debug_pkg.sv
// Shared command/reply codes and state encodings for the UART debug bus master.
package uart_debug_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_PING   = 8'h03;

  localparam logic [7:0] REPLY_ACK  = 8'hA5;
  localparam logic [7:0] REPLY_PONG = 8'h5A;
  localparam logic [7:0] REPLY_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_REPLY
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_debug_phy.sv
// 8N1 serial PHY: synchronised mid-bit RX sampler and back-to-back capable TX shifter.
module uart_debug_phy
  import uart_debug_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_error,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  logic [2:0]    rx_sync;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic          rx_in;
  logic          rx_fall;

  assign rx_in   = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_sync    <= '1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bits    <= '0;
      rx_shift   <= '0;
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      rx_sync    <= {rx_sync[1:0], i_rx};
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_fall) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        // Half a bit in: a line already back high was a glitch, not a start bit.
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_bits  <= '0;
          rx_state <= rx_in ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: if (rx_cnt == LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_in, rx_shift[7:1]};
          rx_bits  <= rx_bits + 3'd1;
          if (rx_bits == 3'd7) rx_state <= RX_STOP;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: if (rx_cnt == LAST) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
          if (rx_in) begin
            o_rx_valid <= 1'b1;
            o_rx_data  <= rx_shift;
          end else begin
            o_rx_error <= 1'b1;
          end
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      endcase
    end
  end

  logic          tx_active;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_idx;
  logic [8:0]    tx_shift;
  logic          tx_end;

  // Ready in the last stop-bit cycle so a queued byte starts with no idle gap.
  assign tx_end     = tx_active && (tx_cnt == LAST) && (tx_idx == 4'd9);
  assign o_tx_ready = !tx_active || tx_end;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '1;
      o_tx      <= 1'b1;
    end else if (i_tx_valid && o_tx_ready) begin
      tx_active <= 1'b1;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= {1'b1, i_tx_data};
      o_tx      <= 1'b0;
    end else if (tx_active) begin
      if (tx_cnt == LAST) begin
        tx_cnt <= '0;
        if (tx_idx == 4'd9) begin
          tx_active <= 1'b0;
          o_tx      <= 1'b1;
        end else begin
          o_tx     <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_idx   <= tx_idx + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_debug_master.sv
// Serial command frames to single-beat 32-bit bus reads/writes, with a serial reply.
module uart_debug_master
  import uart_debug_pkg::*;
#(
  parameter int unsigned FREQUENCY   = 1_000_000,
  parameter int unsigned BAUDRATE    = 115200,
  parameter int unsigned BUS_TIMEOUT = 1024,
  parameter int unsigned RX_TIMEOUT  = FREQUENCY / 100
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_request,
  output logic        o_rw,
  output logic [31:0] o_address,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata,
  input  logic        i_ready,
  output logic        o_busy,
  input  logic        UART_RX,
  output logic        UART_TX
);

  localparam int unsigned DIV = FREQUENCY / BAUDRATE;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  uart_debug_phy #(.DIV(DIV)) u_phy (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_rx       (UART_RX),
    .o_tx       (UART_TX),
    .o_rx_valid (rx_valid),
    .o_rx_data  (rx_data),
    .o_rx_error (rx_error),
    .i_tx_valid (tx_valid),
    .i_tx_data  (tx_data),
    .o_tx_ready (tx_ready)
  );

  state_t      state;
  logic [7:0]  cmd;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [31:0] timer;
  logic [23:0] reply_buf;
  logic [1:0]  reply_left;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      cmd        <= '0;
      is_write   <= 1'b0;
      byte_cnt   <= '0;
      timer      <= '0;
      reply_buf  <= '0;
      reply_left <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      o_request  <= 1'b0;
      o_rw       <= 1'b0;
      o_address  <= '0;
      o_wdata    <= '0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (rx_valid) begin
          cmd    <= rx_data;
          o_busy <= 1'b1;
          state  <= ST_CMD;
        end
        ST_CMD: begin
          byte_cnt <= '0;
          timer    <= '0;
          case (cmd)
            CMD_WRITE: begin is_write <= 1'b1; state <= ST_ADDR; end
            CMD_READ:  begin is_write <= 1'b0; state <= ST_ADDR; end
            CMD_PING:  begin tx_data <= REPLY_PONG; tx_valid <= 1'b1; reply_left <= '0; state <= ST_REPLY; end
            default:   begin tx_data <= REPLY_ERR;  tx_valid <= 1'b1; reply_left <= '0; state <= ST_REPLY; end
          endcase
        end
        // Address and data share one path; the state only picks the target shift register.
        ST_ADDR, ST_DATA: begin
          if (rx_error || timer == RX_TIMEOUT) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (rx_valid) begin
            timer    <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ST_ADDR) o_address <= {rx_data, o_address[31:8]};
            else                  o_wdata   <= {rx_data, o_wdata[31:8]};
            if (byte_cnt == 2'd3) begin
              if (state == ST_ADDR && is_write) begin
                state <= ST_DATA;
              end else begin
                state     <= ST_BUS;
                o_request <= 1'b1;
                o_rw      <= is_write;
              end
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_BUS: begin
          if (i_ready) begin
            o_request <= 1'b0;
            tx_valid  <= 1'b1;
            state     <= ST_REPLY;
            if (is_write) begin
              tx_data    <= REPLY_ACK;
              reply_left <= '0;
            end else begin
              tx_data    <= i_rdata[7:0];
              reply_buf  <= i_rdata[31:8];
              reply_left <= 2'd3;
            end
          end else if (timer == BUS_TIMEOUT - 1) begin
            o_request  <= 1'b0;
            tx_data    <= REPLY_ERR;
            tx_valid   <= 1'b1;
            reply_left <= '0;
            state      <= ST_REPLY;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_REPLY: begin
          if (tx_valid) begin
            if (tx_ready) begin
              if (reply_left != 2'd0) begin
                tx_data    <= reply_buf[7:0];
                reply_buf  <= {8'h00, reply_buf[23:8]};
                reply_left <= reply_left - 2'd1;
              end else begin
                tx_valid <= 1'b0;
              end
            end
          end else if (tx_ready) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_master.sv
// Directed bench for uart_debug_master: serial frames in, decoded replies and bus activity checked.
module tb_uart_debug_master;

  localparam int unsigned DIV           = 10;
  localparam int unsigned TB_RX_TIMEOUT = 300;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        o_request;
  logic        o_rw;
  logic [31:0] o_address;
  logic [31:0] o_wdata;
  logic [31:0] i_rdata = '0;
  logic        i_ready = 1'b0;
  logic        o_busy;
  logic        UART_RX = 1'b1;
  logic        UART_TX;

  always #5 clk = ~clk;

  uart_debug_master #(
    .FREQUENCY   (1_000_000),
    .BAUDRATE    (100_000),
    .BUS_TIMEOUT (1024),
    .RX_TIMEOUT  (TB_RX_TIMEOUT)
  ) dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .o_request (o_request),
    .o_rw      (o_rw),
    .o_address (o_address),
    .o_wdata   (o_wdata),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .UART_RX   (UART_RX),
    .UART_TX   (UART_TX)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: expected reply bytes and expected bus transfer for the current frame.
  logic [7:0]  frame_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_q[$];
  bit          exp_bus_valid = 1'b0;
  logic        exp_rw = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;

  logic        log_rw[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  int unsigned dur_q[$];
  int unsigned req_cycles = 0;

  int unsigned ready_delay = 3;
  bit          bus_hang = 1'b0;
  bit          spurious = 1'b0;

  task automatic model_frame(input bit hang, input logic [31:0] rdata, input bit bad_tail);
    exp_q.delete();
    exp_bus_valid = 1'b0;
    exp_rw        = 1'b0;
    exp_addr      = '0;
    exp_wdata     = '0;
    if (bad_tail || frame_q.size() == 0) return;
    if (frame_q[0] == 8'h01 && frame_q.size() == 9) begin
      exp_bus_valid = 1'b1;
      exp_rw        = 1'b1;
      exp_addr      = {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
      exp_wdata     = {frame_q[8], frame_q[7], frame_q[6], frame_q[5]};
      exp_q.push_back(hang ? 8'hEE : 8'hA5);
    end else if (frame_q[0] == 8'h02 && frame_q.size() == 5) begin
      exp_bus_valid = 1'b1;
      exp_addr      = {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
      if (hang) exp_q.push_back(8'hEE);
      else for (int i = 0; i < 4; i++) exp_q.push_back(8'((rdata >> (8 * i)) & 32'hFF));
    end else if (frame_q[0] == 8'h03 && frame_q.size() == 1) begin
      exp_q.push_back(8'h5A);
    end else if (frame_q[0] > 8'h03 || frame_q[0] == 8'h00) begin
      if (frame_q.size() == 1) exp_q.push_back(8'hEE);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      UART_RX = bits[i];
      repeat (DIV - 1) @(negedge clk);
    end
    if (!stop_ok) begin
      @(negedge clk);
      UART_RX = 1'b1;
      repeat (2 * DIV) @(negedge clk);
    end
  endtask

  // Bus responder: i_ready after ready_delay cycles of o_request, optional stray i_ready while idle.
  initial begin : responder
    int unsigned cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (o_request === 1'b1 && !bus_hang) begin
        cnt++;
        i_ready = (cnt == ready_delay);
      end else begin
        cnt = 0;
        i_ready = spurious;
      end
    end
  end

  // Serial reply decoder.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (i_reset === 1'b1 && UART_TX === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        chk("tx_start_bit", 32'(UART_TX), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = UART_TX;
        end
        repeat (DIV) @(negedge clk);
        chk("tx_stop_bit", 32'(UART_TX), 32'd1);
        tx_q.push_back(b);
      end
    end
  end

  // Compare process: every cycle o_request is up, the bus outputs must match the model.
  initial begin : bus_cmp
    forever begin
      @(negedge clk);
      if (o_request === 1'b1) begin
        req_cycles++;
        chk("bus_expected", 32'(exp_bus_valid), 32'd1);
        chk("bus_rw", 32'(o_rw), 32'(exp_rw));
        chk("bus_addr", o_address, exp_addr);
        if (exp_rw) chk("bus_wdata", o_wdata, exp_wdata);
        chk("bus_busy", 32'(o_busy), 32'd1);
        if (i_ready === 1'b1) begin
          log_rw.push_back(o_rw);
          log_addr.push_back(o_address);
          log_wdata.push_back(o_wdata);
        end
      end else if (req_cycles != 0) begin
        dur_q.push_back(req_cycles);
        req_cycles = 0;
      end
    end
  end

  task automatic clear_logs();
    tx_q.delete();
    log_rw.delete();
    log_addr.delete();
    log_wdata.delete();
    dur_q.delete();
  endtask

  task automatic run_frame(input string name, input bit hang, input logic [31:0] rdata, input bit bad_tail);
    int unsigned n;
    repeat (20) @(negedge clk);
    clear_logs();
    bus_hang = hang;
    i_rdata  = rdata;
    model_frame(hang, rdata, bad_tail);
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    if (bad_tail) send_byte(8'h55, 1'b0);
    if (exp_q.size() > 0) begin
      n = 0;
      while (!(tx_q.size() >= exp_q.size() && o_busy === 1'b0) && n < 6000) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 6000) begin
        errors++;
        $display("FAIL %s_reply_wait: got %0d bytes expected %0d", name, tx_q.size(), exp_q.size());
      end
    end else begin
      repeat (TB_RX_TIMEOUT + 200) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    chk({name, "_reply_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      chk({name, "_reply_byte"}, 32'(tx_q[i]), 32'(exp_q[i]));
    chk({name, "_bus_count"}, log_rw.size(), (exp_bus_valid && !hang) ? 1 : 0);
    if (log_rw.size() > 0 && exp_bus_valid) begin
      chk({name, "_log_rw"}, 32'(log_rw[0]), 32'(exp_rw));
      chk({name, "_log_addr"}, log_addr[0], exp_addr);
      if (exp_rw) chk({name, "_log_wdata"}, log_wdata[0], exp_wdata);
    end
    chk({name, "_busy_idle"}, 32'(o_busy), 32'd0);
    chk({name, "_tx_idle"}, 32'(UART_TX), 32'd1);
  endtask

  initial begin : main
    int unsigned n;
    repeat (3) @(negedge clk);
    chk("rst_request", 32'(o_request), 32'd0);
    chk("rst_rw", 32'(o_rw), 32'd0);
    chk("rst_address", o_address, 32'd0);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_tx", 32'(UART_TX), 32'd1);
    i_reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_tx", 32'(UART_TX), 32'd1);

    // Write with i_ready after 3 cycles.
    frame_q = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ready_delay = 3;
    run_frame("write", 1'b0, 32'h0, 1'b0);
    chk("write_addr_lit", exp_addr, 32'h8000_0010);
    chk("write_wdata_lit", log_wdata.size() > 0 ? log_wdata[0] : 32'h0, 32'hDEAD_BEEF);
    chk("write_reply_lit", tx_q.size() > 0 ? 32'(tx_q[0]) : 32'h0, 32'h0000_00A5);
    chk("write_req_cycles", dur_q.size() > 0 ? dur_q[0] : 0, 32'd3);

    // Read returning 0x12345678.
    frame_q = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h00};
    ready_delay = 2;
    run_frame("read", 1'b0, 32'h1234_5678, 1'b0);
    chk("read_b0_lit", tx_q.size() > 3 ? 32'(tx_q[0]) : 32'h0, 32'h78);
    chk("read_b3_lit", tx_q.size() > 3 ? 32'(tx_q[3]) : 32'h0, 32'h12);
    chk("read_addr_lit", log_addr.size() > 0 ? log_addr[0] : 32'hFFFF_FFFF, 32'h4);

    // Read that never completes.
    frame_q = '{8'h02, 8'h20, 8'h00, 8'h00, 8'h00};
    run_frame("bus_timeout", 1'b1, 32'hCAFE_F00D, 1'b0);
    chk("timeout_req_cycles", dur_q.size() > 0 ? dur_q[0] : 0, 32'd1024);
    chk("timeout_reply_lit", tx_q.size() > 0 ? 32'(tx_q[0]) : 32'h0, 32'hEE);
    bus_hang = 1'b0;

    // Unknown command, then ping with stray i_ready pulses on an idle bus.
    frame_q = '{8'h7F};
    run_frame("bad_cmd", 1'b0, 32'h0, 1'b0);
    spurious = 1'b1;
    frame_q = '{8'h03};
    run_frame("ping", 1'b0, 32'h0, 1'b0);
    spurious = 1'b0;
    chk("ping_reply_lit", tx_q.size() > 0 ? 32'(tx_q[0]) : 32'h0, 32'h5A);

    // Framing error inside a write, then ping.
    frame_q = '{8'h01, 8'h10};
    run_frame("frame_err", 1'b0, 32'h0, 1'b1);
    frame_q = '{8'h03};
    run_frame("ping_after_ferr", 1'b0, 32'h0, 1'b0);

    // Inter-byte gap beyond the receive timeout inside a read, then ping.
    frame_q = '{8'h02, 8'h04};
    run_frame("rx_timeout", 1'b0, 32'h0, 1'b0);
    frame_q = '{8'h03};
    run_frame("ping_after_rxto", 1'b0, 32'h0, 1'b0);

    // Reset while a read is waiting on the bus.
    repeat (20) @(negedge clk);
    clear_logs();
    bus_hang = 1'b1;
    frame_q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00};
    model_frame(1'b1, 32'h0, 1'b0);
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    n = 0;
    while (o_request !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reset_req_seen", 32'(o_request), 32'd1);
    repeat (20) @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("reset_req_drop", 32'(o_request), 32'd0);
    chk("reset_tx_idle", 32'(UART_TX), 32'd1);
    chk("reset_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    bus_hang = 1'b0;
    frame_q = '{8'h03};
    run_frame("ping_after_reset", 1'b0, 32'h0, 1'b0);
    chk("reset_no_reply", tx_q.size(), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
